median_stream_packer: RTL and testbench

//  Downstream stage of the 9-tap median filter. Takes its filtered byte stream (dat_i/val_i, no backpressure).

---
 rtl/median_stream_packer.sv | 115 +++++++++++
 tb/tb_median_stream_packer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_stream_packer.sv
// Burst packer behind the median filter: a one-sample staging register decides
// last-of-burst, then a first-word-fall-through FIFO feeds a valid/ready consumer.
module median_stream_packer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int MAX_BURST = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    dat_i,
    input  logic          val_i,
    output logic [7:0]    dat_o,
    output logic          last_o,
    output logic          val_o,
    input  logic          rdy_i,
    output logic [AW:0]   level_o,
    output logic          ovf_o
);
    localparam int            CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FORCE  = CW'(MAX_BURST - 1);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    // staging register and burst accounting
    logic          stage_full_reg, stage_full_next;
    logic [7:0]    stage_dat_reg, stage_dat_next;
    logic          stage_force_reg, stage_force_next;
    logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
    logic [CW-1:0] cnt_base;

    // FIFO state
    logic [8:0]    mem [DEPTH];
    logic [8:0]    head_word_reg;
    logic          head_val_reg, head_val_next;
    logic [AW:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   level_reg, level_next;
    logic          ovf_reg, ovf_next;

    logic push, push_last, pop, full, wr_en, drop;

    always_comb begin
        // A full stage always empties next cycle; val_i only decides whether it ends the burst.
        push      = stage_full_reg & ~rst;
        push_last = stage_force_reg | ~val_i;

        cnt_base         = (push && push_last) ? '0 : burst_cnt_reg;
        burst_cnt_next   = val_i ? cnt_base + CNT_ONE : cnt_base;
        stage_full_next  = val_i;
        stage_dat_next   = val_i ? dat_i : stage_dat_reg;
        stage_force_next = val_i & (cnt_base == CNT_FORCE);
    end

    always_comb begin
        pop   = head_val_reg & rdy_i;
        full  = (level_reg == LEVEL_FULL);
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_next = wr_en ? wr_ptr_reg + LEVEL_ONE : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + LEVEL_ONE : rd_ptr_reg;

        level_next = level_reg;
        case ({wr_en, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase

        // The head read returns pre-write data, so only entries already stored before
        // this edge may become the head; a freshly written entry shows up one edge later.
        head_val_next = (level_reg > {{AW{1'b0}}, pop});
        ovf_next      = ovf_reg | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_full_reg  <= 1'b0;
            stage_dat_reg   <= 8'h00;
            stage_force_reg <= 1'b0;
            burst_cnt_reg   <= '0;
            head_val_reg    <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            ovf_reg         <= 1'b0;
        end else begin
            stage_full_reg  <= stage_full_next;
            stage_dat_reg   <= stage_dat_next;
            stage_force_reg <= stage_force_next;
            burst_cnt_reg   <= burst_cnt_next;
            head_val_reg    <= head_val_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            level_reg       <= level_next;
            ovf_reg         <= ovf_next;
        end
    end

    // Storage array with registered read, no reset on the data path.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= {push_last, stage_dat_reg};
        end
        head_word_reg <= mem[rd_ptr_next[AW-1:0]];
    end

    assign val_o   = head_val_reg;
    assign dat_o   = head_val_reg ? head_word_reg[7:0] : 8'h00;
    assign last_o  = head_val_reg & head_word_reg[8];
    assign level_o = level_reg;
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_median_stream_packer.sv
// Bench for median_stream_packer: a default instance and a MAX_BURST=4 instance share
// stimulus; popped entries are compared with a burst-splitting reference model.
module tb_median_stream_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dat_i = 8'h00;
    logic       val_i = 1'b0;
    logic       rdy_i = 1'b0;

    logic [7:0] dat_o, dat4_o;
    logic       last_o, last4_o, val_o, val4_o, ovf_o, ovf4_o;
    logic [4:0] level_o, level4_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int first_in_cyc = -1;

    logic [8:0] obs_q[$];
    logic [8:0] obs4_q[$];
    int         obs_cyc_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp4_q[$];
    bit         stim_v[$];
    logic [7:0] stim_d[$];
    bit         stim_r[$];

    median_stream_packer #(.DEPTH(16), .AW(4), .MAX_BURST(64)) u_dut (
        .clk(clk), .rst(rst), .dat_i(dat_i), .val_i(val_i),
        .dat_o(dat_o), .last_o(last_o), .val_o(val_o), .rdy_i(rdy_i),
        .level_o(level_o), .ovf_o(ovf_o)
    );

    median_stream_packer #(.DEPTH(16), .AW(4), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst(rst), .dat_i(dat_i), .val_i(val_i),
        .dat_o(dat4_o), .last_o(last4_o), .val_o(val4_o), .rdy_i(rdy_i),
        .level_o(level4_o), .ovf_o(ovf4_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record every entry that the next rising edge will pop
    always @(negedge clk) begin
        if (!rst) begin
            if (val_o && rdy_i) begin
                obs_q.push_back({last_o, dat_o});
                obs_cyc_q.push_back(cyc);
            end
            if (val4_o && rdy_i) obs4_q.push_back({last4_o, dat4_o});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_obs();
        obs_q.delete();
        obs4_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; val_i = 1'b0; dat_i = 8'h00; rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_obs();
    endtask

    task automatic gen_run(input int n, input int base, input bit r);
        stim_v.delete(); stim_d.delete(); stim_r.delete();
        for (int i = 0; i < n; i++) begin
            stim_v.push_back(1'b1);
            stim_d.push_back(8'(base + i));
            stim_r.push_back(r);
        end
    endtask

    task automatic gen_random(input int n, input int vpct, input int rpct);
        stim_v.delete(); stim_d.delete(); stim_r.delete();
        for (int i = 0; i < n; i++) begin
            stim_v.push_back($urandom_range(99) < vpct);
            stim_d.push_back(8'($urandom_range(255)));
            stim_r.push_back($urandom_range(99) < rpct);
        end
    endtask

    // Reference: each maximal val_i run is cut into chunks of at most MAX_BURST samples,
    // and the final sample of each chunk carries last.
    task automatic build_expected();
        int run, run4;
        bit nxt, l, l4;
        exp_q.delete(); exp4_q.delete();
        run = 0; run4 = 0;
        for (int i = 0; i < stim_v.size(); i++) begin
            if (stim_v[i]) begin
                nxt = (i + 1 < stim_v.size()) ? stim_v[i+1] : 1'b0;
                run++; run4++;
                l  = (run == 64) || !nxt;
                l4 = (run4 == 4) || !nxt;
                exp_q.push_back({l, stim_d[i]});
                exp4_q.push_back({l4, stim_d[i]});
                if (l)  run = 0;
                if (l4) run4 = 0;
            end
        end
    endtask

    task automatic drive_stim();
        first_in_cyc = -1;
        for (int i = 0; i < stim_v.size(); i++) begin
            @(posedge clk); #1;
            val_i = stim_v[i]; dat_i = stim_d[i]; rdy_i = stim_r[i];
            if (stim_v[i] && first_in_cyc < 0) first_in_cyc = cyc;
        end
        @(posedge clk); #1;
        val_i = 1'b0; dat_i = 8'h00;
    endtask

    task automatic drain();
        rdy_i = 1'b1;
        repeat (60) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; val_i = 1'b1; dat_i = 8'hEE; rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; val_i = 1'b0; dat_i = 8'h00;
        @(negedge clk);
        n_cmp++; if (val_o !== 1'b0) begin n_fail++; $display("FAIL reset_val_o got %0b expected 0", val_o); end
        n_cmp++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d expected 0", level_o); end
        n_cmp++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b expected 0", last_o); end
        n_cmp++; if (dat_o !== 8'h00) begin n_fail++; $display("FAIL reset_dat got %02h expected 00", dat_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b expected 0", ovf_o); end
        repeat (3) @(negedge clk);
        n_cmp++; if (val_o !== 1'b0 || level_o !== 5'd0) begin
            n_fail++; $display("FAIL reset_discard got val_o=%0b level=%0d expected 0/0", val_o, level_o);
        end
        $display("reset: val_o=%0b level=%0d ovf=%0b", val_o, level_o, ovf_o);
        clear_obs();
    endtask

    task automatic test_basic_burst();
        do_reset();
        gen_run(5, 8'h10, 1'b1);
        build_expected();
        drive_stim();
        drain();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                   i, obs_q[i][7:0], obs_q[i][8], exp_q[i][7:0], exp_q[i][8]);
            end else $display("basic: entry %0d dat=%02h last=%0b", i, obs_q[i][7:0], obs_q[i][8]);
        end
        // first sample is taken at edge first_in_cyc+1 and must appear two edges later
        if (obs_cyc_q.size() > 0) begin
            n_cmp++;
            if (obs_cyc_q[0] != first_in_cyc + 1 + 2) begin
                n_fail++; $display("FAIL basic_latency got cycle %0d expected %0d", obs_cyc_q[0], first_in_cyc + 3);
            end
        end
    endtask

    task automatic test_single();
        int peak;
        do_reset();
        @(posedge clk); #1; val_i = 1'b1; dat_i = 8'hA5; rdy_i = 1'b1;
        @(posedge clk); #1; val_i = 1'b0; dat_i = 8'h00;
        peak = 0;
        repeat (8) begin
            @(negedge clk);
            if (int'(level_o) > peak) peak = int'(level_o);
        end
        n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0] !== 9'h1A5) begin
                n_fail++; $display("FAIL single_entry got dat=%02h last=%0b expected dat=a5 last=1", obs_q[0][7:0], obs_q[0][8]);
            end else $display("single: dat=%02h last=%0b", obs_q[0][7:0], obs_q[0][8]);
        end
        n_cmp++; if (peak != 1) begin n_fail++; $display("FAIL single_peak_level got %0d expected 1", peak); end
    endtask

    task automatic test_max_burst();
        int lasts;
        do_reset();
        gen_run(10, 0, 1'b1);
        build_expected();
        drive_stim();
        drain();
        n_cmp++; if (obs4_q.size() != exp4_q.size()) begin
            n_fail++; $display("FAIL maxburst_count got %0d expected %0d", obs4_q.size(), exp4_q.size());
        end
        lasts = 0;
        for (int i = 0; i < exp4_q.size() && i < obs4_q.size(); i++) begin
            n_cmp++;
            if (obs4_q[i][8]) lasts++;
            if (obs4_q[i] !== exp4_q[i]) begin
                n_fail++; $display("FAIL maxburst_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                   i, obs4_q[i][7:0], obs4_q[i][8], exp4_q[i][7:0], exp4_q[i][8]);
            end else $display("maxburst: entry %0d dat=%02h last=%0b", i, obs4_q[i][7:0], obs4_q[i][8]);
        end
        n_cmp++; if (lasts != 3) begin n_fail++; $display("FAIL maxburst_bursts got %0d expected 3", lasts); end
    endtask

    task automatic test_long_burst();
        do_reset();
        gen_run(140, 0, 1'b1);
        build_expected();
        drive_stim();
        drain();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL long_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL long_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                   i, obs_q[i][7:0], obs_q[i][8], exp_q[i][7:0], exp_q[i][8]);
            end else $display("long: entry %0d dat=%02h last=%0b", i, obs_q[i][7:0], obs_q[i][8]);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            do_reset();
            if (round == 0) gen_random(250, 50, 85);
            else            gen_random(250, 75, 95);
            build_expected();
            drive_stim();
            drain();
            n_cmp++; if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL random%0d_count got %0d expected %0d", round, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL random%0d_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                       round, i, obs_q[i][7:0], obs_q[i][8], exp_q[i][7:0], exp_q[i][8]);
                end else $display("random%0d: entry %0d dat=%02h last=%0b", round, i, obs_q[i][7:0], obs_q[i][8]);
            end
            n_cmp++; if (obs4_q.size() != exp4_q.size()) begin
                n_fail++; $display("FAIL random%0d_mb4_count got %0d expected %0d", round, obs4_q.size(), exp4_q.size());
            end
            for (int i = 0; i < exp4_q.size() && i < obs4_q.size(); i++) begin
                n_cmp++;
                if (obs4_q[i] !== exp4_q[i]) begin
                    n_fail++; $display("FAIL random%0d_mb4_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                       round, i, obs4_q[i][7:0], obs4_q[i][8], exp4_q[i][7:0], exp4_q[i][8]);
                end else $display("random%0d mb4: entry %0d dat=%02h last=%0b", round, i, obs4_q[i][7:0], obs4_q[i][8]);
            end
            n_cmp++; if (ovf_o !== 1'b0 || level_o !== 5'd0 || dat_o !== 8'h00) begin
                n_fail++; $display("FAIL random%0d_end got ovf=%0b level=%0d dat=%02h expected 0/0/00", round, ovf_o, level_o, dat_o);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        gen_run(20, 0, 1'b0);
        drive_stim();
        repeat (3) @(negedge clk);
        n_cmp++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d expected 16", level_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b expected 1", ovf_o); end
        n_cmp++; if (val_o !== 1'b1 || dat_o !== 8'h00 || last_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_head got val=%0b dat=%02h last=%0b expected 1/00/0", val_o, dat_o, last_o);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (level_o !== 5'd16 || dat_o !== 8'h00 || val_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_hold got level=%0d dat=%02h val=%0b expected 16/00/1", level_o, dat_o, val_o);
        end
        drain();
        n_cmp++; if (obs_q.size() != 16) begin n_fail++; $display("FAIL ovf_drain_count got %0d expected 16", obs_q.size()); end
        for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== {1'b0, 8'(i)}) begin
                n_fail++; $display("FAIL ovf_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=0",
                                   i, obs_q[i][7:0], obs_q[i][8], i);
            end else $display("overflow drain: entry %0d dat=%02h last=%0b", i, obs_q[i][7:0], obs_q[i][8]);
        end
        n_cmp++; if (ovf_o !== 1'b1 || level_o !== 5'd0) begin
            n_fail++; $display("FAIL ovf_sticky got ovf=%0b level=%0d expected 1/0", ovf_o, level_o);
        end
    endtask

    // runs straight after test_overflow so ovf_o starts at 1
    task automatic test_reset_mid();
        rdy_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; val_i = 1'b1; dat_i = 8'(8'h20 + i);
        end
        @(posedge clk); #1; rst = 1'b1; val_i = 1'b1; dat_i = 8'h27;
        @(negedge clk);
        n_cmp++; if (level_o !== 5'd6) begin n_fail++; $display("FAIL midrst_queued got %0d expected 6", level_o); end
        @(negedge clk);
        n_cmp++; if (val_o !== 1'b0 || level_o !== 5'd0 || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear got val=%0b level=%0d ovf=%0b expected 0/0/0", val_o, level_o, ovf_o);
        end
        @(posedge clk); #1; rst = 1'b0; val_i = 1'b0; dat_i = 8'h00;
        clear_obs();
        gen_run(8, 8'h30, 1'b1);
        build_expected();
        drive_stim();
        drain();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL midrst_count got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midrst_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                   i, obs_q[i][7:0], obs_q[i][8], exp_q[i][7:0], exp_q[i][8]);
            end else $display("midrst: entry %0d dat=%02h last=%0b", i, obs_q[i][7:0], obs_q[i][8]);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        // 17 samples fill the FIFO with the 17th staged; from then on every push meets a pop
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1; val_i = 1'b1; dat_i = 8'(i); rdy_i = (i >= 17);
        end
        @(negedge clk);
        n_cmp++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL full_level got %0d expected 16", level_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL full_ovf got %0b expected 0", ovf_o); end
        @(posedge clk); #1; val_i = 1'b0; dat_i = 8'h00;
        drain();
        n_cmp++; if (obs_q.size() != 24) begin n_fail++; $display("FAIL full_count got %0d expected 24", obs_q.size()); end
        for (int i = 0; i < 24 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== {(i == 23), 8'(i)}) begin
                n_fail++; $display("FAIL full_entry[%0d] got dat=%02h last=%0b expected dat=%02h last=%0b",
                                   i, obs_q[i][7:0], obs_q[i][8], i, (i == 23));
            end else $display("full: entry %0d dat=%02h last=%0b", i, obs_q[i][7:0], obs_q[i][8]);
        end
        n_cmp++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL full_ovf_end got %0b expected 0", ovf_o); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_single();
        test_max_burst();
        test_long_burst();
        test_random();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
